// File: rtl/hack_pkg.sv
// Shared word width, step count and state encoding for the sequential multiplier.
package hack_pkg;
  localparam int WORD_W    = 16;
  localparam int MUL_STEPS = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } mul_state_e;
endpackage

// File: rtl/mult16_seq_if.sv
// Start/busy/done handshake plus operand and result buses of mult16_seq.
interface mult16_seq_if;
  import hack_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic [WORD_W-1:0] out;
  logic              busy;
  logic              done;

  modport master (output start, a, b, input out, busy, done);
  modport slave  (input start, a, b, output out, busy, done);
endinterface

// File: rtl/mult16_seq_add16.sv
// Add16: 16-bit ripple-carry adder; the carry out of bit 15 is never formed.
module Add16
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] out
);
  logic [WORD_W-1:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_fa
      assign out[gi] = a[gi] ^ b[gi] ^ carry[gi];
      if (gi < WORD_W - 1) begin : g_carry
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
    end
  endgenerate
endmodule

// File: rtl/mult16_seq.sv
// Sequential shift-and-add multiplier returning the low 16 bits of a*b,
// one multiplier bit per clock through a single Add16.
module mult16_seq
  import hack_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  mult16_seq_if.slave  bus
);
  generate
    if (WIDTH != WORD_W) begin : g_width_check
      $error("mult16_seq: WIDTH must be 16 because the datapath is built on Add16");
    end
  endgenerate

  mul_state_e        state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] mcand_q, mcand_d;
  logic [WORD_W-1:0] mplier_q, mplier_d;
  logic [3:0]        count_q, count_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] sum;
  logic              last_step;

  Add16 u_add16 (
    .a   (acc_q),
    .b   (mcand_q),
    .out (sum)
  );

  // Early exit looks at the multiplier after this step's shift.
  assign last_step = (count_q == 4'(MUL_STEPS - 1)) ||
                     (EARLY_EXIT && (mplier_q[WORD_W-1:1] == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    out_d    = out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          count_d  = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = {mcand_q[WORD_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WORD_W-1:1]};
        count_d  = count_q + 4'd1;
        if (last_step) begin
          state_d = ST_DONE;
          out_d   = acc_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
